// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl: frame/row/column sequencer for the KxK line-buffer window datapath.
// Define CONV_WINDOW_CTRL_ERR_EN to generate the err_sof/err_line protocol error pulses.
module conv_window_ctrl #(
    parameter int KERNEL_SIZE = 5,
    parameter int IMG_WIDTH   = 32,
    parameter int IMG_HEIGHT  = 32,
    parameter int ADDR_W      = $clog2(IMG_WIDTH)
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               s_tvalid,
    output logic                               s_tready,
    input  logic                               s_tuser,
    input  logic                               s_tlast,
    output logic [KERNEL_SIZE-2:0]             lb_we,
    output logic [ADDR_W-1:0]                  lb_waddr,
    output logic [ADDR_W-1:0]                  lb_raddr,
    output logic [$clog2(KERNEL_SIZE-1)-1:0]   rot_sel,
    output logic                               win_shift,
    output logic                               m_tvalid,
    input  logic                               m_tready,
    output logic                               m_tuser,
    output logic                               m_tlast,
    output logic                               err_sof,
    output logic                               err_line
);
    localparam int NB = KERNEL_SIZE - 1;
    localparam int PW = $clog2(KERNEL_SIZE - 1);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [NB-1:0]     ONE       = NB'(1);
    localparam logic [ADDR_W-1:0] COL_K     = ADDR_W'(KERNEL_SIZE - 1);
    localparam logic [ADDR_W-1:0] COL_LAST  = ADDR_W'(IMG_WIDTH - 1);
    localparam logic [RW-1:0]     ROW_K     = RW'(KERNEL_SIZE - 1);
    localparam logic [RW-1:0]     ROW_FLAST = RW'(KERNEL_SIZE - 2);
    localparam logic [RW-1:0]     ROW_LAST  = RW'(IMG_HEIGHT - 1);
    localparam logic [PW-1:0]     PTR_LAST  = PW'(KERNEL_SIZE - 2);

    typedef enum logic [1:0] {WAIT_SOF, FILL, RUN} state_t;

    state_t            state_q, state_d, st_e;
    logic [ADDR_W-1:0] col_q, col_d, col_e;
    logic [RW-1:0]     row_q, row_d, row_e;
    logic [PW-1:0]     ptr_q, ptr_d, ptr_e;
    logic              p1_prod_q, p1_user_q, p1_last_q, win_shift_q;
    logic              m_tvalid_q, m_tuser_q, m_tlast_q;
    logic              accept, write, eol, prod;

    // An SOF pixel restarts the frame, so it is evaluated against zeroed counters.
    always_comb begin
        accept  = s_tvalid && s_tready;
        write   = accept && (s_tuser || state_q != WAIT_SOF);
        st_e    = s_tuser ? FILL : state_q;
        col_e   = s_tuser ? '0 : col_q;
        row_e   = s_tuser ? '0 : row_q;
        ptr_e   = s_tuser ? '0 : ptr_q;
        eol     = write && (s_tlast || col_e == COL_LAST);
        prod    = write && row_e >= ROW_K && col_e >= COL_K;
        col_d   = !write ? col_q : eol ? '0 : col_e + 1'b1;
        row_d   = !write ? row_q : eol ? row_e + 1'b1 : row_e;
        ptr_d   = !write ? ptr_q : !eol ? ptr_e : ptr_e == PTR_LAST ? '0 : ptr_e + 1'b1;
        state_d = !write ? state_q : !eol ? st_e :
                  (st_e == FILL && row_e == ROW_FLAST) ? RUN :
                  (st_e == RUN && row_e == ROW_LAST) ? WAIT_SOF : st_e;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= WAIT_SOF;
            col_q       <= '0;
            row_q       <= '0;
            ptr_q       <= '0;
            p1_prod_q   <= 1'b0;
            p1_user_q   <= 1'b0;
            p1_last_q   <= 1'b0;
            win_shift_q <= 1'b0;
            m_tvalid_q  <= 1'b0;
            m_tuser_q   <= 1'b0;
            m_tlast_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            ptr_q       <= ptr_d;
            p1_prod_q   <= prod;
            p1_user_q   <= prod && row_e == ROW_K && col_e == COL_K;
            p1_last_q   <= prod && col_e == COL_LAST;
            win_shift_q <= write;
            if (p1_prod_q) begin
                m_tvalid_q <= 1'b1;
                m_tuser_q  <= p1_user_q;
                m_tlast_q  <= p1_last_q;
            end else if (m_tready) begin
                m_tvalid_q <= 1'b0;
                m_tuser_q  <= 1'b0;
                m_tlast_q  <= 1'b0;
            end
        end
    end

    // Backpressure holds the next pixel until the pending window has been taken.
    assign s_tready  = !reset && !p1_prod_q && (!m_tvalid_q || m_tready);
    assign lb_we     = write ? ONE << ptr_e : '0;
    assign lb_waddr  = write ? col_e : '0;
    assign lb_raddr  = lb_waddr;
    assign rot_sel   = ptr_q;
    assign win_shift = win_shift_q;
    assign m_tvalid  = m_tvalid_q;
    assign m_tuser   = m_tuser_q;
    assign m_tlast   = m_tlast_q;

`ifdef CONV_WINDOW_CTRL_ERR_EN
    logic err_sof_q, err_line_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            err_sof_q  <= 1'b0;
            err_line_q <= 1'b0;
        end else begin
            err_sof_q  <= accept && (s_tuser != (state_q == WAIT_SOF));
            err_line_q <= write && (s_tlast != (col_e == COL_LAST));
        end
    end

    assign err_sof  = err_sof_q;
    assign err_line = err_line_q;
`else
    assign err_sof  = 1'b0;
    assign err_line = 1'b0;
`endif
endmodule

// File: tb/tb_conv_window_ctrl.sv
// tb_conv_window_ctrl: directed stimulus with a reference model and a window scoreboard.
module tb_conv_window_ctrl;
    localparam int K = 5, W = 32, H = 32, AW = 5, PW = 2;
    localparam int M_WAIT = 0, M_FILL = 1, M_RUN = 2;
`ifdef CONV_WINDOW_CTRL_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clock = 1'b0, reset = 1'b1;
    logic          s_tvalid = 1'b0, s_tuser = 1'b0, s_tlast = 1'b0, m_tready = 1'b1;
    logic          s_tready, win_shift, m_tvalid, m_tuser, m_tlast, err_sof, err_line;
    logic [K-2:0]  lb_we;
    logic [AW-1:0] lb_waddr, lb_raddr;
    logic [PW-1:0] rot_sel;

    always #5 clock = ~clock;

    conv_window_ctrl #(.KERNEL_SIZE(K), .IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_W(AW)) dut (
        .clock(clock), .reset(reset), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .s_tuser(s_tuser), .s_tlast(s_tlast), .lb_we(lb_we), .lb_waddr(lb_waddr),
        .lb_raddr(lb_raddr), .rot_sel(rot_sel), .win_shift(win_shift),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tuser(m_tuser), .m_tlast(m_tlast),
        .err_sof(err_sof), .err_line(err_line)
    );

    int n_checks = 0, n_pass = 0, n_fail = 0;
    int b_state = M_WAIT, b_col = 0, b_row = 0, b_ptr = 0;
    int n_win = 0, n_user = 0, n_last = 0;
    bit stall_pend = 1'b0;
    logic [1:0] exp_q[$];
    logic       prev_v = 1'b0;
    logic [1:0] prev_m = 2'b00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Window monitor: samples the values the next rising edge will see.
    always @(negedge clock) begin
        #2;
        if (reset) prev_v = 1'b0;
        else begin
            if (prev_v) check("window_hold", {m_tvalid, m_tuser, m_tlast}, {1'b1, prev_m});
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) check("unexpected_window", exp_q.size(), 1);
                else begin
                    check("window_markers", {m_tuser, m_tlast}, exp_q.pop_front());
                    n_win++;
                    n_user += int'(m_tuser);
                    n_last += int'(m_tlast);
                end
            end
            prev_v = m_tvalid && !m_tready;
            prev_m = {m_tuser, m_tlast};
        end
    end

    task automatic do_stall();
        stall_pend = 1'b0;
        check("stall_first_user", m_tuser, 1);
        m_tready = 1'b0;
        repeat (10) begin
            #1;
            check("stall_s_tready", s_tready, 0);
            check("stall_m_tvalid", m_tvalid, 1);
            @(negedge clock);
        end
        m_tready = 1'b1;
    endtask

    task automatic send_pixel(input bit u, input bit l);
        bit wr, es, el, prod;
        int ce, re, pe, se, waited;
        logic [K-2:0] one, we_e;
        one = 1;
        wr = (b_state != M_WAIT) || u;
        es = ERR_EN && (u != (b_state == M_WAIT));
        ce = u ? 0 : b_col;
        re = u ? 0 : b_row;
        pe = u ? 0 : b_ptr;
        se = u ? M_FILL : b_state;
        el = ERR_EN && wr && (l != (ce == W - 1));
        prod = wr && re >= K - 1 && ce >= K - 1;
        we_e = wr ? one << pe : '0;
        s_tvalid = 1'b1;
        s_tuser = u;
        s_tlast = l;
        waited = 0;
        forever begin
            if (stall_pend && m_tvalid) do_stall();
            #1;
            if (s_tready) break;
            waited++;
            if (waited > 50) begin
                check("accept_timeout", waited, 0);
                $display("%0d/%0d checks passed", n_pass, n_checks);
                $fatal(1, "FAIL accept_timeout: pixel never accepted");
            end
            @(negedge clock);
        end
        check("lb_we", lb_we, we_e);
        if (wr) begin
            check("lb_waddr", lb_waddr, ce);
            check("lb_raddr", lb_raddr, ce);
        end
        if (prod) exp_q.push_back({re == K - 1 && ce == K - 1, ce == W - 1});
        if (wr) begin
            if (l || ce == W - 1) begin
                b_col = 0;
                b_row = re + 1;
                b_ptr = (pe == K - 2) ? 0 : pe + 1;
                b_state = (se == M_FILL && re == K - 2) ? M_RUN :
                          (se == M_RUN && re == H - 1) ? M_WAIT : se;
            end else begin
                b_col = ce + 1;
                b_row = re;
                b_ptr = pe;
                b_state = se;
            end
        end
        @(negedge clock);
        s_tvalid = 1'b0;
        s_tuser = 1'b0;
        s_tlast = 1'b0;
        check("win_shift", win_shift, wr);
        check("err_sof", err_sof, es);
        check("err_line", err_line, el);
        check("rot_sel", rot_sel, b_ptr);
        if (m_tready) check("s_tready_after", s_tready, !prod);
    endtask

    task automatic send_lines(input bit first_user, input int rows, input int tail,
                              input int early_row, input int early_col);
        for (int r = 0; r <= rows; r++) begin
            int len;
            len = (r == rows) ? tail : (r == early_row) ? early_col + 1 : W;
            for (int c = 0; c < len; c++)
                send_pixel(first_user && r == 0 && c == 0, r != rows && c == len - 1);
        end
    endtask

    task automatic drain(input string tag, input int ew, input int eu, input int el);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clock);
        check({tag, "_pending"}, exp_q.size(), 0);
        check({tag, "_windows"}, n_win, ew);
        check({tag, "_tuser"}, n_user, eu);
        check({tag, "_tlast"}, n_last, el);
        n_win = 0;
        n_user = 0;
        n_last = 0;
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check("reset_s_tready", s_tready, 0);
        check("reset_outputs", {lb_we, lb_waddr, lb_raddr, rot_sel, win_shift, m_tvalid,
                                m_tuser, m_tlast, err_sof, err_line}, 0);
        reset = 1'b0;
        #1;
        check("post_reset_s_tready", s_tready, 1);
        @(negedge clock);
        repeat (3) send_pixel(1'b0, 1'b0);
        send_lines(1'b1, H, 0, -1, -1);
        drain("frame", 784, 1, 28);
        stall_pend = 1'b1;
        send_lines(1'b1, H, 0, -1, -1);
        check("stall_done", stall_pend, 0);
        drain("stall", 784, 1, 28);
        send_lines(1'b1, H, 0, 3, 20);
        drain("early_tlast", 784, 1, 28);
        send_lines(1'b1, 10, 5, -1, -1);
        send_lines(1'b1, H, 0, -1, -1);
        drain("sof_restart", 953, 2, 34);
        send_lines(1'b1, 4, 5, -1, -1);
        m_tready = 1'b0;
        @(negedge clock);
        check("pre_reset_m_tvalid", m_tvalid, 1);
        reset = 1'b1;
        @(negedge clock);
        check("midrun_reset_outputs", {s_tready, lb_we, lb_waddr, lb_raddr, rot_sel,
                                       win_shift, m_tvalid, m_tuser, m_tlast, err_sof,
                                       err_line}, 0);
        reset = 1'b0;
        exp_q.delete();
        b_state = M_WAIT;
        b_col = 0;
        b_row = 0;
        b_ptr = 0;
        n_win = 0;
        n_user = 0;
        n_last = 0;
        #1;
        check("midrun_reset_s_tready", s_tready, 1);
        m_tready = 1'b1;
        @(negedge clock);
        send_pixel(1'b0, 1'b0);
        send_lines(1'b1, H, 0, -1, -1);
        drain("after_reset", 784, 1, 28);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/conv_window_ctrl.md
# conv_window_ctrl

Sequencing controller for the K×K convolution line-buffer datapath. It tracks frame, row and column position on the incoming AXI-Stream pixel stream. It drives the K-1 line-buffer BRAM write enables and addresses, the row-rotation select and the window-shift strobe, and generates the output window stream handshake with its frame and line markers. Pixel data does not pass through this block; the sequencing controls only.

## Interface
Parameters:
- KERNEL_SIZE, 5, kernel edge K; the line buffer holds K-1 rows.
- IMG_WIDTH, 32, pixels per line.
- IMG_HEIGHT, 32, lines per frame.
- ADDR_W, $clog2(IMG_WIDTH), line-buffer address width.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- s_tvalid  in  1  input pixel valid
- s_tready  out  1  input pixel accept
- s_tuser  in  1  start of frame, first pixel
- s_tlast  in  1  end of line
- lb_we  out  KERNEL_SIZE-1  one-hot line-buffer write enable
- lb_waddr  out  ADDR_W  write address, equal to the current column
- lb_raddr  out  ADDR_W  read address, equal to lb_waddr (BRAM is read-old-data)
- rot_sel  out  $clog2(KERNEL_SIZE-1)  index of the buffer holding the oldest row
- win_shift  out  1  shift the window register by one column
- m_tvalid  out  1  window valid
- m_tready  in  1  window consumed
- m_tuser  out  1  first window of frame
- m_tlast  out  1  last window of output row
- err_sof  out  1  protocol error pulse, SOF
- err_line  out  1  protocol error pulse, line length

## Operation
- Accept occurs when s_tvalid and s_tready are both high. Counters are col (0..IMG_WIDTH-1), row (0..IMG_HEIGHT-1) and wr_ptr (0..K-2).
- On accept, lb_we[wr_ptr] = 1 and lb_waddr = lb_raddr = col. lb_we is 0 on all other cycles and in WAIT_SOF.
- rot_sel = wr_ptr. The datapath orders top-to-bottom taps as buf[wr_ptr], buf[(wr_ptr+1) mod (K-1)], …, followed by the delayed live pixel.
- End of line occurs on an accepted pixel with s_tlast, or at col == IMG_WIDTH-1, whichever comes first. At end of line:
  - col resets to 0 and row increments.
  - wr_ptr wraps from K-2 to 0.
- Producing pixel: an accepted pixel with row ≥ K-1 and col ≥ K-1.
- States:
  - WAIT_SOF (reset state): an accept with s_tuser goes to FILL with row = col = wr_ptr = 0, and that pixel is written. An accept without s_tuser drops the pixel and pulses err_sof.
  - FILL (row < K-1): at end of line of row K-2, go to RUN.
  - RUN: at end of line of row IMG_HEIGHT-1, go to WAIT_SOF.
  - s_tuser on an accept in FILL or RUN pulses err_sof and restarts the frame at that pixel, with counters at 0 and state FILL.
- Output markers:
  - m_tuser = 1 for the window from row K-1, col K-1.
  - m_tlast = 1 for the window from col IMG_WIDTH-1.
  - Windows per frame: (IMG_WIDTH-K+1)×(IMG_HEIGHT-K+1).
- err_line pulses on an s_tlast with col ≠ IMG_WIDTH-1, or at col == IMG_WIDTH-1 without s_tlast.

## Timing
- Reset values: s_tready 0 during reset and 1 in the first cycle after; all other outputs 0; state WAIT_SOF.
- Accept at cycle t:
  - win_shift = 1 at t+1, aligned with BRAM rdata.
  - For a producing pixel, m_tvalid = 1 from t+2, with m_tuser/m_tlast valid at the same time.
- m_tvalid, m_tuser and m_tlast hold stable until m_tready is sampled high.
- s_tready = !p1_prod && (!m_tvalid || m_tready), where p1_prod is "the pixel accepted last cycle is producing". This guarantees the window is not shifted before it is consumed.
- Throughput: 1 pixel/cycle in non-producing regions; 1 pixel per 2 cycles in producing regions with m_tready held high.
- Error pulses are 1 cycle wide and occur in the cycle after the offending accept.
- Reset mid-frame aborts immediately. No window is emitted after reset and any pending m_tvalid is cleared.

## Configuration
- CONV_WINDOW_CTRL_ERR_EN defined: err_sof and err_line are generated as specified.
- Not defined: err_sof and err_line are tied to 0 and the checking logic is omitted. Dropping and restart behaviour is unchanged.

## Test plan
- Default params, one 32×32 frame, m_tready = 1: 784 windows, one m_tuser at the first window, 28 m_tlast pulses, no errors.
- Output stall: hold m_tready = 0 for 10 cycles at the first window. m_tvalid and markers stay stable, s_tready = 0, no window is lost, and the count is still 784.
- Early s_tlast at col 20 on row 3: err_line pulses once, row 4 starts at col 0, and wr_ptr advances to 0 (wrap from 3).
- s_tuser at row 10 col 5: err_sof pulses, the frame restarts, and the next m_tuser appears after 4 full lines plus 4 pixels.
- Pixels before the first s_tuser after reset: all are dropped with lb_we = 0 and one err_sof pulse each. With the macro undefined, err_sof stays 0.
- Reset asserted mid-RUN while m_tvalid = 1: the next cycle shows all outputs at 0 and state WAIT_SOF, and a new frame yields 784 windows.
